alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU instance between two requesters.
- Each requester issues an operation through a valid/ready handshake. The arbiter grants round-robin, registers operands into the ALU, captures result and flags, and returns a tagged response through a valid/ready response channel.
- Sits between the ALU and its clients (e.g. the main datapath and a branch-compare unit).

Parameters:
- DATA_W, 32, operand/result width
- CTRL_W, 4, ALU_control width
- BONUS_W, 3, bonus_control width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept, at most one bit set
- req_src1  in  2*DATA_W  operand 1, requester i at [i*DATA_W +: DATA_W]
- req_src2  in  2*DATA_W  operand 2, same packing
- req_ctrl  in  2*CTRL_W  ALU_control per requester
- req_bonus  in  2*BONUS_W  bonus_control per requester
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  1  requester index of the response
- resp_result  out  DATA_W  captured ALU result
- resp_flags  out  3  {overflow, cout, zero} captured
- resp_err  out  1  illegal ALU_control code
- alu_src1  out  DATA_W  to ALU src1
- alu_src2  out  DATA_W  to ALU src2
- alu_ctrl  out  CTRL_W  to ALU ALU_control
- alu_bonus  out  BONUS_W  to ALU bonus_control
- alu_rst_n  out  1  to ALU rst_n
- alu_result  in  DATA_W  from ALU result
- alu_flags  in  3  from ALU {overflow, cout, zero}

Behaviour:
- Legal ALU_control codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
  - Any other code is illegal.
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: resp_valid=0, resp_id=0, resp_result=0, resp_flags=0, resp_err=0, alu_src1/src2=0, alu_ctrl=0010, alu_bonus=0, last_grant=1 (requester 0 wins the first tie).
- alu_rst_n = ~rst_i, purely combinational.
- IDLE:
  - grant = one-hot among req_valid. If both bits are set, grant the index != last_grant.
  - req_ready = grant. req_ready is combinational from req_valid and state, and is 0 outside IDLE.
  - On req_valid[i] & req_ready[i]:
    - register src1, src2, ctrl, bonus into the alu_* outputs;
    - latch id=i and last_grant=i;
    - go to EXEC.
- EXEC (1 cycle): the ALU settles combinationally. At the closing edge:
  - resp_result <= alu_result; resp_flags <= alu_flags.
  - If ctrl is illegal: resp_result <= 0, resp_flags <= 0, resp_err <= 1. Otherwise resp_err <= 0.
  - resp_valid <= 1; go to RESP.
- RESP:
  - resp_valid, resp_id, resp_result, resp_flags and resp_err hold stable until resp_ready=1.
  - On that edge: resp_valid <= 0, go to IDLE.
  - No new request is accepted in RESP.
- Latency: accept edge -> resp_valid high 2 cycles later. Minimum 3 cycles per operation.
- alu_* outputs hold their last values in IDLE and RESP. The ALU result is sampled only at the end of EXEC.
- Requester payload may change freely while its req_ready=0. It is sampled only on the accept edge.
- A requester that drops req_valid before grant loses nothing. There is no queueing.
- Starvation-free: with both requesters continuously valid, grants alternate 0,1,0,1…
- rst_i asserted in any state:
  - immediate return to IDLE with reset values;
  - an in-flight operation is discarded with no response;
  - requesters must reissue.
- resp_ready high while resp_valid=0 has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_NAND);
  - flag bit indices (FLG_ZERO=0, FLG_COUT=1, FLG_OVF=2);
  - FSM state encoding.
- One sub-module, rr_arbiter2: a 2-way round-robin grant from req_valid and last_grant, combinational.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- Requester 0 issues ADD 0x00000003 + 0x00000004 -> accepted with req_ready=01; 2 cycles later resp_valid=1, resp_id=0, resp_result=0x00000007, zero=0, resp_err=0.
- Requester 1 issues SUB 0x00000005 - 0x00000005, resp_ready held 0 for 4 cycles -> resp_result=0x00000000, zero=1, outputs stable all 4 cycles; req_ready=00 throughout; IDLE after resp_ready=1.
- Both requesters continuously valid, 4 operations -> resp_id sequence 0,1,0,1; first grant to requester 0 after reset.
- Requester 0 issues ctrl=0011 with src1=0xFFFFFFFF -> resp_err=1, resp_result=0, resp_flags=000.
- ADD 0xFFFFFFFF + 0x00000001 -> resp_result=0, cout=1, zero=1. Then SLT 3 vs 7 -> resp_result=0x00000001.
- rst_i pulsed during EXEC -> resp_valid stays 0, all outputs at reset values, no response emitted. A request issued after reset completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, flag bit positions, arbiter FSM states.
package alu_pkg;

  localparam int unsigned ALU_DATA_W  = 32;
  localparam int unsigned ALU_CTRL_W  = 4;
  localparam int unsigned ALU_BONUS_W = 3;
  localparam int unsigned ALU_FLAG_W  = 3;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  localparam int unsigned FLG_ZERO = 0;
  localparam int unsigned FLG_COUT = 1;
  localparam int unsigned FLG_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for the seven codes the ALU implements.
  function automatic logic ctrl_legal(input logic [3:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_NOR, ALU_NAND: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time wins.
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with a tagged,
// valid/ready response channel; one operation in flight at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = ALU_DATA_W,
  parameter int unsigned CTRL_W  = ALU_CTRL_W,
  parameter int unsigned BONUS_W = ALU_BONUS_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*DATA_W-1:0]    req_src1,
  input  logic [2*DATA_W-1:0]    req_src2,
  input  logic [2*CTRL_W-1:0]    req_ctrl,
  input  logic [2*BONUS_W-1:0]   req_bonus,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_id,
  output logic [DATA_W-1:0]      resp_result,
  output logic [ALU_FLAG_W-1:0]  resp_flags,
  output logic                   resp_err,
  output logic [DATA_W-1:0]      alu_src1,
  output logic [DATA_W-1:0]      alu_src2,
  output logic [CTRL_W-1:0]      alu_ctrl,
  output logic [BONUS_W-1:0]     alu_bonus,
  output logic                   alu_rst_n,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [ALU_FLAG_W-1:0]  alu_flags
);

  state_t     r_state;
  logic       r_last;
  logic       r_id;
  logic [1:0] w_grant;
  logic       w_id;
  logic       w_accept;

  rr_arbiter2 u_rr (
    .req_valid  (req_valid),
    .last_grant (r_last),
    .grant      (w_grant)
  );

  assign req_ready = (r_state == ST_IDLE) ? w_grant : 2'b00;
  assign w_accept  = |req_ready;
  assign w_id      = w_grant[1];
  assign alu_rst_n = ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_flags  <= '0;
      resp_err    <= 1'b0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      alu_ctrl    <= CTRL_W'(ALU_ADD);
      alu_bonus   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            alu_src1  <= w_id ? req_src1[2*DATA_W-1:DATA_W]   : req_src1[DATA_W-1:0];
            alu_src2  <= w_id ? req_src2[2*DATA_W-1:DATA_W]   : req_src2[DATA_W-1:0];
            alu_ctrl  <= w_id ? req_ctrl[2*CTRL_W-1:CTRL_W]   : req_ctrl[CTRL_W-1:0];
            alu_bonus <= w_id ? req_bonus[2*BONUS_W-1:BONUS_W] : req_bonus[BONUS_W-1:0];
            r_id      <= w_id;
            r_last    <= w_id;
            r_state   <= ST_EXEC;
          end
        end
        // ALU output has had a full cycle to settle; illegal codes report a clean zero result.
        ST_EXEC: begin
          if (ctrl_legal(ALU_CTRL_W'(alu_ctrl))) begin
            resp_result <= alu_result;
            resp_flags  <= alu_flags;
            resp_err    <= 1'b0;
          end else begin
            resp_result <= '0;
            resp_flags  <= '0;
            resp_err    <= 1'b1;
          end
          resp_id    <= r_id;
          resp_valid <= 1'b1;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
